// File: rtl/pipelined_word_reducer.sv
// Pipelined OR/AND/XOR reduction of WORD_COUNT words to one word, with per-word
// masking, identity padding to a power of two and a register every REG_STRIDE levels.
module prw_combine #(
  parameter int W = 36
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  always_comb begin
    case (op)
      2'b01:   y = a & b;
      2'b10:   y = a ^ b;
      default: y = a | b;
    endcase
  end
endmodule

module pipelined_word_reducer #(
  parameter int WORD_WIDTH = 36,
  parameter int WORD_COUNT = 16,
  parameter int REG_STRIDE = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             in_valid,
  input  logic [1:0]                       in_op,
  input  logic [WORD_COUNT-1:0]            in_mask,
  input  logic [WORD_WIDTH*WORD_COUNT-1:0] in,
  output logic                             out_valid,
  output logic [WORD_WIDTH-1:0]            out,
  output logic                             out_zero
);
  localparam int LEVELS = (WORD_COUNT <= 1) ? 1 : $clog2(WORD_COUNT);
  localparam int LEAVES = 1 << LEVELS;
  localparam int NREG   = (LEVELS + REG_STRIDE - 1) / REG_STRIDE;

  logic [WORD_COUNT-1:0][WORD_WIDTH-1:0] s0_data;
  logic [WORD_COUNT-1:0]                 s0_mask;
  logic [NREG:0]                         vld_pipe;
  logic [NREG-1:0][1:0]                  op_pipe;
  logic [WORD_WIDTH-1:0]                 ident;

  // Valid and op travel as shift registers; op_pipe[r] is the op seen by the
  // tree levels that follow register r (register 0 is the input stage).
  always_ff @(posedge clock) begin
    if (reset) begin
      s0_data  <= '0;
      s0_mask  <= '0;
      vld_pipe <= '0;
      op_pipe  <= '0;
    end else if (enable) begin
      s0_data     <= in;
      s0_mask     <= in_mask;
      vld_pipe[0] <= in_valid;
      op_pipe[0]  <= (in_op == 2'b11) ? 2'b00 : in_op;
      for (int r = 1; r <= NREG; r++) vld_pipe[r] <= vld_pipe[r-1];
      for (int r = 1; r < NREG; r++)  op_pipe[r]  <= op_pipe[r-1];
    end
  end

  assign ident = (op_pipe[0] == 2'b01) ? '1 : '0;

  for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
    localparam int N = LEAVES >> k;
    logic [N-1:0][WORD_WIDTH-1:0] data;

    if (k == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_word
        if (i < WORD_COUNT) begin : g_real
          assign data[i] = s0_mask[i] ? s0_data[i] : ident;
        end else begin : g_pad
          assign data[i] = ident;
        end
      end
    end else begin : g_tree
      localparam bit IS_REG = ((k % REG_STRIDE) == 0) || (k == LEVELS);
      logic [N-1:0][WORD_WIDTH-1:0] comb;

      for (genvar j = 0; j < N; j++) begin : g_node
        prw_combine #(.W(WORD_WIDTH)) u_comb (
          .op (op_pipe[(k-1)/REG_STRIDE]),
          .a  (g_lvl[k-1].data[2*j]),
          .b  (g_lvl[k-1].data[2*j+1]),
          .y  (comb[j])
        );
      end

      if (IS_REG) begin : g_reg
        always_ff @(posedge clock) begin
          if (reset)       data <= '0;
          else if (enable) data <= comb;
        end
      end else begin : g_wire
        assign data = comb;
      end
    end
  end

  // Data in bubbles is don't-care inside the tree, so the output is gated.
  assign out_valid = vld_pipe[NREG];
  assign out       = out_valid ? g_lvl[LEVELS].data[0] : '0;
  assign out_zero  = out_valid & ~|out;
endmodule

// File: tb/tb_pipelined_word_reducer.sv
// Bench for pipelined_word_reducer: directed vector table on the default build plus
// a scoreboard per configuration checking every cycle against a flat reference reduction.
module tb_pipelined_word_reducer;
  localparam int W    = 36;
  localparam int NCFG = 7;
  localparam int CWC [NCFG] = '{16, 16, 16, 5, 5, 2, 1};
  localparam int CST [NCFG] = '{2, 1, 3, 1, 3, 2, 1};
  localparam int L0   = 3;
  localparam int NV   = 10;

  logic          clock, reset, enable, in_valid;
  logic [1:0]    in_op;
  logic [15:0]   in_mask;
  logic [16*W-1:0] in_bus;
  logic [NCFG-1:0]        ov, oz;
  logic [NCFG-1:0][W-1:0] oo;

  int n_err = 0;
  int n_chk = 0;
  logic chk_on = 1'b0;
  logic final_chk = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [W-1:0] ref_reduce(input logic [1:0] op, input logic [15:0] m,
                                               input logic [16*W-1:0] d, input int wc);
    logic [W-1:0] acc;
    acc = (op == 2'b01) ? '1 : '0;
    for (int i = 0; i < wc; i++) begin
      if (m[i]) begin
        case (op)
          2'b01:   acc = acc & d[i*W +: W];
          2'b10:   acc = acc ^ d[i*W +: W];
          default: acc = acc | d[i*W +: W];
        endcase
      end
    end
    return acc;
  endfunction

  task automatic check(input string nm, input logic [W+1:0] got, input logic [W+1:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got={v,z,out}=%h want=%h", nm, got, want);
    end
  endtask

  for (genvar c = 0; c < NCFG; c++) begin : g_cfg
    localparam int LV  = (CWC[c] <= 1) ? 1 : $clog2(CWC[c]);
    localparam int LAT = 1 + (LV + CST[c] - 1) / CST[c];

    pipelined_word_reducer #(.WORD_WIDTH(W), .WORD_COUNT(CWC[c]), .REG_STRIDE(CST[c])) u_dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .in_valid  (in_valid),
      .in_op     (in_op),
      .in_mask   (in_mask[CWC[c]-1:0]),
      .in        (in_bus[CWC[c]*W-1:0]),
      .out_valid (ov[c]),
      .out       (oo[c]),
      .out_zero  (oz[c])
    );

    int           due_q[$];
    logic [W-1:0] val_q[$];
    int           ecnt = 0;
    logic         exp_v = 1'b0;
    logic [W-1:0] exp_o = '0;
    logic         fin_done = 1'b0;

    // Expected output only changes on enabled edges; a result is due LAT enabled edges after launch.
    always @(posedge clock) begin
      if (reset) begin
        due_q.delete();
        val_q.delete();
        exp_v = 1'b0;
        exp_o = '0;
      end else if (enable) begin
        if (in_valid) begin
          due_q.push_back(ecnt + LAT);
          val_q.push_back(ref_reduce(in_op, in_mask, in_bus, CWC[c]));
        end
        ecnt++;
        if (due_q.size() > 0 && due_q[0] == ecnt) begin
          exp_v = 1'b1;
          exp_o = val_q.pop_front();
          void'(due_q.pop_front());
        end else begin
          exp_v = 1'b0;
          exp_o = '0;
        end
      end
    end

    always @(negedge clock) begin
      if (chk_on) begin
        n_chk++;
        if (ov[c] !== exp_v || oo[c] !== exp_o || oz[c] !== (exp_v && exp_o == '0)) begin
          n_err++;
          $display("FAIL sb_cfg%0d t=%0t got v=%b z=%b out=%h want v=%b out=%h",
                   c, $time, ov[c], oz[c], oo[c], exp_v, exp_o);
        end
      end
      if (final_chk && !fin_done) begin
        fin_done = 1'b1;
        n_chk++;
        if (due_q.size() != 0) begin
          n_err++;
          $display("FAIL drain_cfg%0d pending=%0d want 0", c, due_q.size());
        end
      end
    end
  end

  typedef struct {
    logic [1:0]   op;
    logic [15:0]  mask;
    logic [W-1:0] base;
    int           ia;
    logic [W-1:0] wa;
    int           ib;
    logic [W-1:0] wb;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl [NV];

  task automatic drive_vec(input vec_t v);
    for (int i = 0; i < 16; i++) in_bus[i*W +: W] = v.base;
    in_bus[v.ia*W +: W] = v.wa;
    in_bus[v.ib*W +: W] = v.wb;
    in_op    = v.op;
    in_mask  = v.mask;
    in_valid = 1'b1;
  endtask

  task automatic rand_in();
    logic dense;
    logic [W-1:0] w;
    dense = ($urandom_range(0, 1) == 1);
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 5) == 0)  w = '1;
      else if (dense)                 w = ~(W'(1) << $urandom_range(0, W-1));
      else                            w = W'({$urandom(), $urandom()});
      in_bus[i*W +: W] = w;
    end
    in_op    = 2'($urandom_range(0, 3));
    in_mask  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom());
    in_valid = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    int sent;
    tbl[0] = '{2'b00, 16'hFFFF, 36'h0,         3, 36'h000000001, 15, 36'h800000000, 36'h800000001};
    tbl[1] = '{2'b01, 16'hFFFF, 36'hFFFFFFFFF, 7, 36'hFFFFFFFF0,  7, 36'hFFFFFFFF0, 36'hFFFFFFFF0};
    tbl[2] = '{2'b10, 16'hFFFF, 36'h123456789, 0, 36'h123456789,  0, 36'h123456789, 36'h000000000};
    tbl[3] = '{2'b00, 16'h0000, 36'hFFFFFFFFF, 0, 36'hFFFFFFFFF,  0, 36'hFFFFFFFFF, 36'h000000000};
    tbl[4] = '{2'b01, 16'h0000, 36'h0,         0, 36'h0,          0, 36'h0,         36'hFFFFFFFFF};
    tbl[5] = '{2'b01, 16'h0001, 36'h123456789, 0, 36'h0000000AA,  0, 36'h0000000AA, 36'h0000000AA};
    tbl[6] = '{2'b11, 16'hFFFF, 36'h0,         2, 36'h0000000FF,  9, 36'h00000000F, 36'h0000000FF};
    tbl[7] = '{2'b10, 16'h00FF, 36'h0,         0, 36'h000000005,  8, 36'h000000003, 36'h000000005};
    tbl[8] = '{2'b10, 16'hFFFF, 36'h0,         0, 36'h000000005,  8, 36'h000000003, 36'h000000006};
    tbl[9] = '{2'b01, 16'hFFFF, 36'hFFFFFFFFF, 0, 36'hF0F0F0F0F, 15, 36'hFFFF0000F, 36'hF0F00000F};

    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_mask = '0; in_bus = '0;
    repeat (3) @(negedge clock);
    check("reset_state", {ov[0], oz[0], oo[0]}, '0);
    reset  = 1'b0;
    chk_on = 1'b1;

    // Directed table, back-to-back; each result must appear exactly L0 cycles after launch.
    for (int t = 0; t < NV + L0; t++) begin
      @(negedge clock);
      if (t >= L0) check($sformatf("tbl%0d", t - L0), {ov[0], oz[0], oo[0]},
                         {1'b1, tbl[t-L0].exp == '0, tbl[t-L0].exp});
      if (t < NV) drive_vec(tbl[t]);
      else        in_valid = 1'b0;
    end

    // Freeze for 3 cycles mid-flight while junk is presented.
    @(negedge clock);
    drive_vec(tbl[9]);
    @(negedge clock);
    enable = 1'b0;
    rand_in();
    in_valid = 1'b1;
    repeat (3) @(negedge clock);
    enable = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    check("freeze_early", {ov[0], oz[0], oo[0]}, '0);
    @(negedge clock);
    check("freeze_result", {ov[0], oz[0], oo[0]}, {2'b10, 36'hF0F00000F});
    enable = 1'b0;
    @(negedge clock);
    check("freeze_hold", {ov[0], oz[0], oo[0]}, {2'b10, 36'hF0F00000F});
    enable = 1'b1;
    @(negedge clock);

    // Reset mid-flight discards the transfer.
    drive_vec(tbl[0]);
    @(negedge clock);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("reset_flush%0d", i), {ov[0], oz[0], oo[0]}, '0);
      @(negedge clock);
    end

    // Random stream with random enable.
    sent = 0;
    while (sent < 1000) begin
      rand_in();
      enable = ($urandom_range(0, 4) != 0);
      if (enable && in_valid) sent++;
      @(negedge clock);
    end
    enable = 1'b1;
    in_valid = 1'b0;
    repeat (8) @(negedge clock);
    final_chk = 1'b1;
    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
